// File: rtl/proc_pkg.sv
// proc_pkg: widths and instruction field bounds shared by the processor and its fetch stage
package proc_pkg;
  localparam int ADDR_W = 8;
  localparam int INSTR_W = 29;
  localparam int OPC_HI = 28;
  localparam int OPC_LO = 24;
  typedef logic [OPC_HI-OPC_LO:0] opcode_t;
  function automatic opcode_t opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPC_HI:OPC_LO];
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous circular queue with push, pop and flush; head gated to 0 while empty
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 37
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  logic [W-1:0]                 wdata_i,
  output logic [W-1:0]                 rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  // Guard both strobes locally so occupancy can never over- or underflow
  assign do_pop = pop_i && cnt_q != '0;
  assign do_push = push_i && (cnt_q != FULL || do_pop);
  always_comb begin
    rd_d = flush_i ? '0 : do_pop ? rd_q + PW'(1) : rd_q;
    wr_d = flush_i ? '0 : do_push ? wr_q + PW'(1) : wr_q;
    cnt_d = flush_i ? '0 : (do_push && !do_pop) ? cnt_q + CW'(1) :
            (do_pop && !do_push) ? cnt_q - CW'(1) : cnt_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
  end
  assign rdata_o = cnt_q != '0 ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;
endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: fetch PC and redirect control feeding a decoupling instruction queue
module instr_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = proc_pkg::ADDR_W,
  parameter int INSTR_W = proc_pkg::INSTR_W
) (
  input  logic                         in_clk,
  input  logic                         in_rst,
  output logic [ADDR_W-1:0]            out_pm_addr,
  input  logic [INSTR_W-1:0]           in_pm_instr,
  input  logic                         in_redirect,
  input  logic [ADDR_W-1:0]            in_redirect_addr,
  input  logic                         in_halt,
  output logic                         out_valid,
  input  logic                         in_ready,
  output logic [INSTR_W-1:0]           out_instr,
  output logic [ADDR_W-1:0]            out_instr_pc,
  output logic [$clog2(DEPTH+1)-1:0]   out_count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W+INSTR_W-1:0] head;
  logic pop, push;
  assign pop = out_valid && in_ready;
  // A full queue still accepts a fetch when the head leaves in the same cycle
  assign push = !in_redirect && !in_halt && (out_count != FULL || pop);
  always_comb begin
    pc_d = in_redirect ? in_redirect_addr : push ? pc_q + ADDR_W'(1) : pc_q;
  end
  always_ff @(posedge in_clk) begin
    if (!in_rst) pc_q <= '0;
    else pc_q <= pc_d;
  end
  fetch_fifo #(
    .DEPTH(DEPTH),
    .W(ADDR_W + INSTR_W)
  ) u_fifo (
    .clk_i(in_clk),
    .rst_ni(in_rst),
    .push_i(push),
    .pop_i(pop),
    .flush_i(in_redirect),
    .wdata_i({pc_q, in_pm_instr}),
    .rdata_o(head),
    .count_o(out_count)
  );
  assign out_pm_addr = pc_q;
  assign out_valid = out_count != '0;
  assign {out_instr_pc, out_instr} = head;
endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: instruction queue entries; power of two, 2..16.
REQ-002 SHALL have parameter ADDR_W, default 8: program counter and program memory address width.
REQ-003 SHALL have parameter INSTR_W, default 29: instruction word width.
REQ-004 SHALL have port in_clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port in_rst, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port out_pm_addr, output, ADDR_W: program memory read address, equal to the fetch PC.
REQ-007 SHALL have port in_pm_instr, input, INSTR_W: combinational program memory read data for out_pm_addr in the same cycle.
REQ-008 SHALL have port in_redirect, input, 1: jump taken; flush the queue and restart fetching.
REQ-009 SHALL have port in_redirect_addr, input, ADDR_W: jump target, sampled when in_redirect=1.
REQ-010 SHALL have port in_halt, input, 1: suspend new fetches while 1.
REQ-011 SHALL have port out_valid, output, 1: the queue head is presented.
REQ-012 SHALL have port in_ready, input, 1: decode accepts the head.
REQ-013 SHALL have port out_instr, output, INSTR_W: head instruction word.
REQ-014 SHALL have port out_instr_pc, output, ADDR_W: address the head instruction was fetched from.
REQ-015 SHALL have port out_count, output, $clog2(DEPTH+1): current occupancy.

Function
REQ-016 Pop SHALL occur when out_valid=1 and in_ready=1. out_instr and out_instr_pc SHALL stay stable while out_valid=1 and in_ready=0.
REQ-017 Push SHALL occur when in_redirect=0, in_halt=0, and (count<DEPTH or pop). Push writes {out_pm_addr, in_pm_instr} at the tail and sets fetch PC to fetch PC+1, modulo 2^ADDR_W (255 wraps to 0).
REQ-018 When no push occurs, fetch PC SHALL hold its value; out_pm_addr SHALL remain driven.
REQ-019 A pushed entry SHALL be visible at the head no earlier than the cycle after the push; there is no combinational bypass from in_pm_instr to out_instr.
REQ-020 Simultaneous push and pop SHALL leave count unchanged. When full with pop, the push SHALL be accepted in the same cycle.
REQ-021 Redirect SHALL take priority over push and halt. On redirect:
- count goes to 0 and the read and write pointers reset next cycle.
- fetch PC takes in_redirect_addr.
- no push occurs that cycle.
REQ-022 A pop handshake in the same cycle as in_redirect SHALL still complete for the consumer; the flush discards all other entries.
REQ-023 After a redirect in cycle N: out_valid=0 in cycle N+1; the in_redirect_addr entry is pushed in N+1 and presented with out_valid=1 in N+2, provided halt is low.
REQ-024 Halt SHALL block pushes only; pops continue until the queue is empty.
REQ-025 out_valid SHALL equal (count!=0). out_count SHALL never exceed DEPTH and never underflow.
REQ-026 Pointers SHALL be log2(DEPTH) bits wide and wrap naturally at DEPTH.

Reset
REQ-027 While in_rst=0 at a clock edge, the block SHALL reset: fetch PC=0, pointers=0, count=0.
REQ-028 Outputs in reset SHALL be: out_valid=0, out_count=0, out_pm_addr=0, out_instr=0, out_instr_pc=0.
REQ-029 Reset mid-operation SHALL discard all queued entries with no partial pop. The first push after release SHALL be address 0, in the first cycle with in_rst=1.
REQ-030 Queue storage contents SHALL not require reset; the outputs are gated to 0 while the queue is empty.

Structure
REQ-031 Shared package proc_pkg SHALL hold ADDR_W, INSTR_W and the opcode field bounds [28:24]. The top-level processor and this block SHALL both use it.
REQ-032 Queue storage and pointers SHALL be a sub-module fetch_fifo: synchronous, with push, pop and flush inputs. PC and redirect logic SHALL stay in instr_fetch_queue.

Verification
REQ-033 Startup: hold in_rst=0 for 3 cycles, then release with in_ready=1 and memory mem[i]=i. Required: out_pm_addr 0,1,2,…; out_valid rises 1 cycle after release; out_instr_pc sequence 0,1,2 with no gaps.
REQ-034 Backpressure: in_ready=0 for 10 cycles with DEPTH=4. Required: count reaches 4; out_pm_addr holds at 4; head stays at PC 0; after in_ready=1, pops deliver PCs 0..7 in order.
REQ-035 Redirect: in_redirect=1 with in_redirect_addr=0x40 while count=3. Required: next cycle out_valid=0 and count=0; one cycle later out_instr_pc=0x40 and out_valid=1.
REQ-036 Wrap: redirect to 0xFE with in_ready=1. Required: delivered PCs are 0xFE, 0xFF, 0x00, 0x01.
REQ-037 Full with simultaneous pop: count=4 and in_ready=1. Required: push and pop in the same cycle; count stays 4 with no lost or duplicated PC.
REQ-038 Reset mid-stream: in_rst=0 for one cycle while count=2 and redirect=1. Required: all outputs 0 next cycle; fetch restarts at PC 0.
